// File: rtl/encoder_rr_queue.sv
// encoder_rr_queue: holds a multi-hot request vector and emits the index of each set bit,
// one per handshake beat, using fixed or round-robin priority.
module encoder_rr_queue #(
   parameter int IN_W  = 8,
   parameter int OUT_W = $clog2(IN_W),
   parameter int MODE  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out,
   output logic             out_last,
   output logic [IN_W-1:0]  pending
);
   logic [OUT_W-1:0] ptr, lo_idx, hi_idx, sel;
   logic hi_hit, pop, load;
   // Descending scan so the last hit is the lowest index in each class.
   always_comb begin
      lo_idx = '0;
      hi_idx = '0;
      hi_hit = 1'b0;
      for (int i = IN_W - 1; i >= 0; i--) begin
         if (pending[i]) lo_idx = OUT_W'(i);
         if (pending[i] && i >= int'(ptr)) begin
            hi_idx = OUT_W'(i);
            hi_hit = 1'b1;
         end
      end
   end
   assign sel       = (MODE == 1 && hi_hit) ? hi_idx : lo_idx;
   assign out       = sel;
   assign out_valid = |pending;
   assign out_last  = out_valid && ((pending & (pending - IN_W'(1))) == '0);
   assign pop       = out_valid && out_ready;
   assign in_ready  = !out_valid || (pop && out_last);
   assign load      = in_valid && in_ready;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         ptr     <= '0;
      end else begin
         if (load) pending <= in;
         else if (pop) pending <= pending & ~(IN_W'(1) << sel);
         if (pop && MODE == 1) ptr <= (sel == OUT_W'(IN_W - 1)) ? '0 : sel + 1'b1;
      end
   end
endmodule

// File: tb/tb_encoder_rr_queue.sv
// tb_encoder_rr_queue: scoreboard bench for a fixed-priority 8-bit lane and a
// round-robin 5-bit lane, both driven with random and directed vectors.
module tb_encoder_rr_queue;
   typedef struct {int idx; bit last;} ent_t;
   typedef logic [7:0] vq_t[$];

   logic clk, rst, out_ready;
   logic in_valid_a, in_ready_a, out_valid_a, out_last_a;
   logic [7:0] in_a, pending_a;
   logic [2:0] out_a;
   logic in_valid_b, in_ready_b, out_valid_b, out_last_b;
   logic [4:0] in_b, pending_b;
   logic [2:0] out_b;

   logic       vv[2], acc[2], rdy_exp[2];
   logic [7:0] vin[2];
   logic       ov[2], ir[2], ol[2];
   logic [7:0] oidx[2], pend[2];
   ent_t q[2][$];
   vq_t  dir[2];
   int   mptr[2];
   int   w_of[2] = '{8, 5};
   int   mode_of[2] = '{0, 1};
   int   n_cmp = 0, n_bad = 0;
   bit   did_rst = 0;

   encoder_rr_queue #(.IN_W(8), .MODE(0)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in(in_a),
      .out_valid(out_valid_a), .out_ready(out_ready), .out(out_a), .out_last(out_last_a),
      .pending(pending_a));
   encoder_rr_queue #(.IN_W(5), .MODE(1)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in(in_b),
      .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b), .out_last(out_last_b),
      .pending(pending_b));

   assign in_valid_a = vv[0];
   assign in_a       = vin[0];
   assign in_valid_b = vv[1];
   assign in_b       = vin[1][4:0];
   assign ov[0] = out_valid_a;  assign ov[1] = out_valid_b;
   assign ir[0] = in_ready_a;   assign ir[1] = in_ready_b;
   assign ol[0] = out_last_a;   assign ol[1] = out_last_b;
   assign oidx[0] = {5'b0, out_a};
   assign oidx[1] = {5'b0, out_b};
   assign pend[0] = pending_a;
   assign pend[1] = {3'b0, pending_b};

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int l, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s lane%0d: got %0d expected %0d", nm, l, act, exp);
      end
   endtask

   // Reference: expand a vector into its index sequence by the priority rules.
   task automatic push_vec(input int l, input logic [7:0] v);
      logic [7:0] r;
      int idx;
      r = v;
      while (r != 0) begin
         idx = -1;
         if (mode_of[l] == 1)
            for (int i = mptr[l]; i < w_of[l]; i++) if (r[i] && idx < 0) idx = i;
         if (idx < 0)
            for (int i = 0; i < w_of[l]; i++) if (r[i] && idx < 0) idx = i;
         r[idx] = 1'b0;
         q[l].push_back('{idx, r == 0});
         if (mode_of[l] == 1) mptr[l] = (idx + 1) % w_of[l];
      end
   endtask

   initial begin
      logic [7:0] ep;
      bit ev;
      forever begin
         @(negedge clk);
         for (int l = 0; l < 2; l++) begin
            ev = q[l].size() != 0;
            ep = 8'h00;
            for (int k = 0; k < q[l].size(); k++) ep[q[l][k].idx] = 1'b1;
            chk("out_valid", l, int'(ov[l]), int'(ev));
            if (ev) begin
               chk("out", l, int'(oidx[l]), q[l][0].idx);
               chk("out_last", l, int'(ol[l]), int'(q[l][0].last));
            end else begin
               chk("idle_out", l, int'(oidx[l]), 0);
               chk("idle_last", l, int'(ol[l]), 0);
            end
            chk("pending", l, int'(pend[l]), int'(ep));
            rdy_exp[l] = ev ? (out_ready && q[l][0].last) : 1'b1;
            chk("in_ready", l, int'(ir[l]), int'(rdy_exp[l]));
            if (ev && out_ready) void'(q[l].pop_front());
         end
      end
   end

   initial begin
      rst = 1;
      out_ready = 0;
      dir[0] = '{8'hA4, 8'h24, 8'h01, 8'h80, 8'h00, 8'hFF};
      dir[1] = '{8'h11, 8'h06, 8'h00, 8'h1F, 8'h10};
      for (int l = 0; l < 2; l++) begin
         vv[l] = 0; acc[l] = 0; vin[l] = 0; mptr[l] = 0; rdy_exp[l] = 1;
      end
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(posedge clk);
         #1;
         if (rst) rst = 0;
         out_ready = (cyc >= 1950) ? 1'b1 : ($urandom_range(0, 3) != 0);
         for (int l = 0; l < 2; l++) begin
            if (!vv[l] || acc[l]) begin
               acc[l] = 0;
               if (cyc < 1900 && $urandom_range(0, 9) < 7) begin
                  vv[l] = 1;
                  if (dir[l].size() != 0) vin[l] = dir[l].pop_front();
                  else vin[l] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
                  if (l == 1) vin[l] = vin[l] & 8'h1F;
               end else vv[l] = 0;
            end
         end
         // Async reset in the middle of a round-robin drain.
         if (!did_rst && cyc >= 300 && q[1].size() >= 2) begin
            #2;
            rst = 1;
            for (int l = 0; l < 2; l++) begin
               q[l].delete(); mptr[l] = 0; vv[l] = 0; vin[l] = 0; acc[l] = 0;
            end
            #1;
            chk("rst_out_valid", 1, int'(ov[1]), 0);
            chk("rst_pending", 1, int'(pend[1]), 0);
            chk("rst_pending", 0, int'(pend[0]), 0);
            did_rst = 1;
         end
         @(negedge clk);
         #2;
         for (int l = 0; l < 2; l++)
            if (vv[l] && rdy_exp[l] && !rst) begin
               push_vec(l, vin[l]);
               acc[l] = 1;
            end
      end
      chk("reset_applied", 0, int'(did_rst), 1);
      chk("drained", 0, q[0].size(), 0);
      chk("drained", 1, q[1].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
